// File: rtl/debug_display_pager_pkg.sv
// Shared constants, source encodings and converter state type for the debug display pager.
package debug_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_NUM_DIGITS  = 4;
    localparam int unsigned DEF_LINE_W      = 8;
    localparam int unsigned DEF_LINE_DIGITS = 3;

    localparam int unsigned PAGES  = DEF_DATA_W / (4 * DEF_NUM_DIGITS);
    localparam int unsigned PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned BCD_W  = 4 * DEF_LINE_DIGITS;

    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Width of the page index for a given word/digit geometry (at least one bit).
    function automatic int unsigned page_w_of(int unsigned data_w, int unsigned num_digits);
        int unsigned pages;
        pages = data_w / (4 * num_digits);
        return (pages > 1) ? $clog2(pages) : 1;
    endfunction

    // 10^n, used to check that the BCD field can hold the largest line number.
    function automatic longint unsigned pow10(int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/debug_display_pager_if.sv
// Debugger-side bus between the board controls, the peek sources and the display pager.
interface debug_display_pager_if #(
    parameter int unsigned DATA_W      = debug_pkg::DEF_DATA_W,
    parameter int unsigned NUM_DIGITS  = debug_pkg::DEF_NUM_DIGITS,
    parameter int unsigned LINE_DIGITS = debug_pkg::DEF_LINE_DIGITS
);
    localparam int unsigned PAGE_W = debug_pkg::page_w_of(DATA_W, NUM_DIGITS);

    logic [9:0]               switches;
    logic                     page_btn;
    logic                     auto_en;
    logic [DATA_W-1:0]        regData;
    logic [DATA_W-1:0]        memData;
    logic [31:0]              address;
    logic [4:0]               regToPeek;
    logic [31:0]              memToPeek;
    logic [4*NUM_DIGITS-1:0]  dig_out;
    logic [PAGE_W-1:0]        page;
    logic [4*LINE_DIGITS-1:0] line_bcd;
    logic                     line_busy;

    modport master (
        output switches, page_btn, auto_en, regData, memData, address,
        input  regToPeek, memToPeek, dig_out, page, line_bcd, line_busy
    );

    modport slave (
        input  switches, page_btn, auto_en, regData, memData, address,
        output regToPeek, memToPeek, dig_out, page, line_bcd, line_busy
    );

endinterface

// File: rtl/debug_display_pager_bcd_seq.sv
// Sequential double-dabble converter: binary line number to BCD, one bit per cycle.
module bcd_seq
    import debug_pkg::*;
#(
    parameter int unsigned LINE_W      = DEF_LINE_W,
    parameter int unsigned LINE_DIGITS = DEF_LINE_DIGITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LINE_W-1:0]        line_v,
    output logic [4*LINE_DIGITS-1:0] line_bcd,
    output logic                     line_busy
);
    localparam int unsigned BCD_BITS = 4 * LINE_DIGITS;
    localparam int unsigned CNT_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    if (pow10(LINE_DIGITS) <= ((64'(1) << LINE_W) - 64'(1))) begin : g_bad_digits
        $error("bcd_seq: LINE_DIGITS too small for LINE_W");
    end

    bcd_state_t          state_q, state_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic [LINE_W-1:0]   sh_q,    sh_d;
    logic [BCD_BITS-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BCD_BITS-1:0] bcd_q,   bcd_d;
    logic                busy_q,  busy_d;
    logic [BCD_BITS-1:0] adj;

    // Next-state: latch a new line, shift LINE_W times with add-3 correction, publish.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        adj     = acc_q;
        for (int unsigned d = 0; d < LINE_DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (line_v != line_q) begin
                    line_d  = line_v;
                    sh_d    = line_v;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {adj[BCD_BITS-2:0], sh_q[LINE_W-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LINE_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
        end
    end

    assign line_bcd  = bcd_q;
    assign line_busy = busy_q;

endmodule

// File: rtl/debug_display_pager.sv
// Debugger display front end: peek select, coherent snapshot, hex paging and line number.
module debug_display_pager
    import debug_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int unsigned LINE_W      = DEF_LINE_W,
    parameter int unsigned LINE_DIGITS = DEF_LINE_DIGITS,
    parameter int unsigned PAGE_CYCLES = 50000000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    debug_display_pager_if.slave  bus
);
    localparam int unsigned SLICE_W = 4 * NUM_DIGITS;
    localparam int unsigned N_PAGES = DATA_W / SLICE_W;
    localparam int unsigned PG_W    = page_w_of(DATA_W, NUM_DIGITS);
    localparam int unsigned TIMER_W = (PAGE_CYCLES > 2) ? $clog2(PAGE_CYCLES) : 1;

    if ((DATA_W % SLICE_W) != 0) begin : g_bad_data_w
        $error("debug_display_pager: DATA_W must be a multiple of 4*NUM_DIGITS");
    end
    if (PAGE_CYCLES < 2) begin : g_bad_page_cycles
        $error("debug_display_pager: PAGE_CYCLES must be >= 2");
    end

    logic [9:0]         sw_q,        sw_d;
    logic               btn_q,       btn_d;
    logic               reload_q,    reload_d;
    logic [4:0]         reg_peek_q,  reg_peek_d;
    logic [31:0]        mem_peek_q,  mem_peek_d;
    logic [DATA_W-1:0]  snap_q,      snap_d;
    logic [PG_W-1:0]    page_q,      page_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic [SLICE_W-1:0] dig_q,       dig_d;
    logic               btn_rise;
    logic               tmo;
    logic [DATA_W-1:0]  src_word;
    logic               unused_addr;

    // Peek select, snapshot reload and page advance; a pending reload outranks an advance.
    always_comb begin
        sw_d       = bus.switches;
        btn_d      = bus.page_btn;
        reg_peek_d = bus.switches[4:0];
        mem_peek_d = {23'b0, bus.switches[8:0]};
        reload_d   = (bus.switches != sw_q);
        btn_rise   = bus.page_btn & ~btn_q;
        tmo        = bus.auto_en & (timer_q == TIMER_W'(PAGE_CYCLES - 1));
        src_word   = (sw_q[9] == SRC_MEM) ? bus.memData : bus.regData;
        snap_d     = snap_q;
        page_d     = page_q;
        timer_d    = bus.auto_en ? timer_q + 1'b1 : '0;
        if (reload_q) begin
            snap_d  = src_word;
            page_d  = '0;
            timer_d = '0;
        end else if (btn_rise | tmo) begin
            timer_d = '0;
            if (page_q == PG_W'(N_PAGES - 1)) begin
                page_d = '0;
                snap_d = src_word;
            end else begin
                page_d = page_q + 1'b1;
            end
        end
        dig_d = snap_q[SLICE_W * int'(page_q) +: SLICE_W];
    end

    // All paging state registered with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sw_q       <= '0;
            btn_q      <= 1'b0;
            reload_q   <= 1'b0;
            reg_peek_q <= '0;
            mem_peek_q <= '0;
            snap_q     <= '0;
            page_q     <= '0;
            timer_q    <= '0;
            dig_q      <= '0;
        end else begin
            sw_q       <= sw_d;
            btn_q      <= btn_d;
            reload_q   <= reload_d;
            reg_peek_q <= reg_peek_d;
            mem_peek_q <= mem_peek_d;
            snap_q     <= snap_d;
            page_q     <= page_d;
            timer_q    <= timer_d;
            dig_q      <= dig_d;
        end
    end

    assign bus.regToPeek = reg_peek_q;
    assign bus.memToPeek = mem_peek_q;
    assign bus.dig_out   = dig_q;
    assign bus.page      = page_q;

    // Only the word-aligned line bits of the address are displayed.
    assign unused_addr = ^{bus.address[31:LINE_W+2], bus.address[1:0]};

    bcd_seq #(
        .LINE_W      (LINE_W),
        .LINE_DIGITS (LINE_DIGITS)
    ) u_bcd_seq (
        .clk       (Clk),
        .rst       (Rst),
        .line_v    (bus.address[LINE_W+1:2]),
        .line_bcd  (bus.line_bcd),
        .line_busy (bus.line_busy)
    );

endmodule
